// File: rtl/scan_pkg.sv
// Shared definitions for the scan controller: one-hot state encoding,
// state bit positions and a constant-evaluable clog2 helper.
package scan_pkg;

    localparam int ST_W  = 6;

    localparam int B_RS  = 0;
    localparam int B_RI  = 1;
    localparam int B_CAP = 2;
    localparam int B_SH  = 3;
    localparam int B_EX  = 4;
    localparam int B_UP  = 5;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_RS  = 6'b000001;
    localparam state_t ST_RI  = 6'b000010;
    localparam state_t ST_CAP = 6'b000100;
    localparam state_t ST_SH  = 6'b001000;
    localparam state_t ST_EX  = 6'b010000;
    localparam state_t ST_UP  = 6'b100000;

    // Smallest r with 2**r >= value (value >= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < 32'(value)) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_ctrl_if.sv
// Serial test port plus parallel test-register bus of the scan controller.
// With SCAN_BYPASS_EN defined the bus carries the extra byp select.
interface scan_ctrl_if #(parameter int DW = 8);

    logic          x;
    logic          tdi;
    logic          tdo;
    logic [DW-1:0] par_in;
    logic [DW-1:0] par_out;
    logic          reset;
    logic          run;
    logic          capture;
    logic          shift;
    logic          update;
    logic          len_err;
`ifdef SCAN_BYPASS_EN
    logic          byp;

    modport master (
        output x, tdi, par_in, byp,
        input  tdo, par_out, reset, run, capture, shift, update, len_err
    );

    modport slave (
        input  x, tdi, par_in, byp,
        output tdo, par_out, reset, run, capture, shift, update, len_err
    );
`else
    modport master (
        output x, tdi, par_in,
        input  tdo, par_out, reset, run, capture, shift, update, len_err
    );

    modport slave (
        input  x, tdi, par_in,
        output tdo, par_out, reset, run, capture, shift, update, len_err
    );
`endif

endinterface

// File: rtl/scan_sreg.sv
// DW-bit capture/shift/update register with shift-length counter.
// Actions apply on the edge that leaves the state whose enable is high.
// SCAN_BYPASS_EN adds a 1-bit bypass path selected at capture time.
module scan_sreg
    import scan_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rs,
    input  logic          cap_en,
    input  logic          shift_en,
    input  logic          upd_en,
    input  logic          tdi,
`ifdef SCAN_BYPASS_EN
    input  logic          byp,
`endif
    input  logic [DW-1:0] par_in,
    output logic [DW-1:0] par_out,
    output logic          len_err,
    output logic          tdo
);

    localparam int            CW       = clog2(DW + 2);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DW + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DW);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [DW-1:0] sr_r;
    logic [DW-1:0] par_out_r;
    logic [CW-1:0] cnt_r;
    logic          len_err_r;
    logic          cap_byp_s;
    logic          byp_mode_s;
    logic          tdo_bit_s;
    logic [CW-1:0] exp_cnt_s;
    logic          len_ok_s;

`ifdef SCAN_BYPASS_EN
    logic byp_q_r;
    logic byp_bit_r;

    assign cap_byp_s  = byp;
    assign byp_mode_s = byp_q_r;
    assign tdo_bit_s  = byp_q_r ? byp_bit_r : sr_r[0];

    // Latch the bypass select at capture and shift through the 1-bit bypass reg.
    always_ff @(posedge clk) begin
        if (rs) begin
            byp_q_r   <= 1'b0;
            byp_bit_r <= 1'b0;
        end else if (cap_en) begin
            byp_q_r   <= byp;
            byp_bit_r <= 1'b0;
        end else if (shift_en && byp_q_r) begin
            byp_q_r   <= byp_q_r;
            byp_bit_r <= tdi;
        end else begin
            byp_q_r   <= byp_q_r;
            byp_bit_r <= byp_bit_r;
        end
    end
`else
    assign cap_byp_s  = 1'b0;
    assign byp_mode_s = 1'b0;
    assign tdo_bit_s  = sr_r[0];
`endif

    assign exp_cnt_s = byp_mode_s ? CNT_ONE : CNT_FULL;
    assign len_ok_s  = (cnt_r == exp_cnt_s);
    assign tdo       = shift_en ? tdo_bit_s : 1'b0;
    assign par_out   = par_out_r;
    assign len_err   = len_err_r;

    // Shift register: parallel capture, LSB-first serial shift toward tdo.
    always_ff @(posedge clk) begin
        if (rs) begin
            sr_r <= '0;
        end else if (cap_en && !cap_byp_s) begin
            sr_r <= par_in;
        end else if (shift_en && !byp_mode_s) begin
            sr_r <= {tdi, sr_r[DW-1:1]};
        end else begin
            sr_r <= sr_r;
        end
    end

    // Shift counter: cleared at capture, saturates one past a full scan.
    always_ff @(posedge clk) begin
        if (rs) begin
            cnt_r <= '0;
        end else if (cap_en) begin
            cnt_r <= '0;
        end else if (shift_en && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Update register: only a correctly sized, non-bypass scan is committed.
    always_ff @(posedge clk) begin
        if (rs) begin
            par_out_r <= '0;
        end else if (upd_en && len_ok_s && !byp_mode_s) begin
            par_out_r <= sr_r;
        end else begin
            par_out_r <= par_out_r;
        end
    end

    // Length error: one-cycle pulse after leaving update with a bad count.
    always_ff @(posedge clk) begin
        if (rs) begin
            len_err_r <= 1'b0;
        end else begin
            len_err_r <= upd_en && !len_ok_s;
        end
    end

endmodule

// File: rtl/scan_ctrl.sv
// Scan-mode controller: one-hot Moore FSM (RS/RI/CAP/SH/EX/UP) steered by x,
// forced return to RS after RST_CNT consecutive x=1 edges, and the owned
// capture/shift/update register (scan_sreg).
// Optional feature macro: SCAN_BYPASS_EN (1-bit bypass path, byp input).
module scan_ctrl
    import scan_pkg::*;
#(
    parameter int DW      = 8,
    parameter int RST_CNT = 5
) (
    input  logic        clk,
    input  logic        rs,
    scan_ctrl_if.slave  bus
);

    localparam int            XW       = clog2(RST_CNT);
    localparam logic [XW-1:0] XRUN_MAX = XW'(RST_CNT - 1);
    localparam logic [XW-1:0] XRUN_ONE = XW'(1);

    state_t        state_r;
    state_t        table_next_s;
    state_t        state_next_s;
    logic [XW-1:0] xrun_r;
    logic          force_rs_s;

    assign force_rs_s = bus.x && (xrun_r == XRUN_MAX);

    // State register.
    always_ff @(posedge clk) begin
        if (rs) begin
            state_r <= ST_RS;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Run-length of consecutive x=1 edges, saturating at the force threshold.
    always_ff @(posedge clk) begin
        if (rs) begin
            xrun_r <= '0;
        end else if (!bus.x) begin
            xrun_r <= '0;
        end else if (xrun_r != XRUN_MAX) begin
            xrun_r <= xrun_r + XRUN_ONE;
        end else begin
            xrun_r <= xrun_r;
        end
    end

    // Next state: transition table, overridden by the forced reset.
    always_comb begin
        table_next_s = ST_RS;
        case (state_r)
            ST_RS:   table_next_s = bus.x ? ST_RS  : ST_RI;
            ST_RI:   table_next_s = bus.x ? ST_CAP : ST_RI;
            ST_CAP:  table_next_s = bus.x ? ST_EX  : ST_SH;
            ST_SH:   table_next_s = bus.x ? ST_EX  : ST_SH;
            ST_EX:   table_next_s = bus.x ? ST_UP  : ST_SH;
            ST_UP:   table_next_s = bus.x ? ST_CAP : ST_RI;
            default: table_next_s = ST_RS;
        endcase
        if (force_rs_s) begin
            state_next_s = ST_RS;
        end else begin
            state_next_s = table_next_s;
        end
    end

    // Moore outputs taken straight from the state bits.
    always_comb begin
        bus.reset   = state_r[B_RS];
        bus.run     = state_r[B_RI];
        bus.capture = state_r[B_CAP];
        bus.shift   = state_r[B_SH];
        bus.update  = state_r[B_UP];
    end

    scan_sreg #(
        .DW (DW)
    ) u_sreg (
        .clk      (clk),
        .rs       (rs),
        .cap_en   (state_r[B_CAP]),
        .shift_en (state_r[B_SH]),
        .upd_en   (state_r[B_UP]),
        .tdi      (bus.tdi),
`ifdef SCAN_BYPASS_EN
        .byp      (bus.byp),
`endif
        .par_in   (bus.par_in),
        .par_out  (bus.par_out),
        .len_err  (bus.len_err),
        .tdo      (bus.tdo)
    );

endmodule

// File: tb/tb_scan_ctrl.sv
// Directed bench for scan_ctrl (DW=8, RST_CNT=5). Expected outputs are
// queued when each step is driven and checked one edge later.
module tb_scan_ctrl;

    localparam logic [5:0] F_RS  = 6'b100000;
    localparam logic [5:0] F_RI  = 6'b010000;
    localparam logic [5:0] F_CAP = 6'b001000;
    localparam logic [5:0] F_SH  = 6'b000100;
    localparam logic [5:0] F_EX  = 6'b000000;
    localparam logic [5:0] F_UP  = 6'b000010;
    localparam logic [5:0] F_LE  = 6'b000001;

    typedef struct {
        logic [5:0] flags;
        logic       tdo;
        logic [7:0] par;
        string      tag;
    } exp_t;

    logic clk;
    logic rs;
    int   n_tests;
    int   n_fail;
    exp_t sb_q[$];

    scan_ctrl_if #(.DW(8)) bus ();

    scan_ctrl #(
        .DW      (8),
        .RST_CNT (5)
    ) dut (
        .clk (clk),
        .rs  (rs),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge's inputs, queue its expectation, check after the edge.
    task automatic step(input logic xi, input logic ti, input logic ri,
                        input logic [5:0] ef, input logic et,
                        input logic [7:0] ep, input string tag);
        exp_t e;
        exp_t g;
        logic [5:0] flags;
        bus.x   = xi;
        bus.tdi = ti;
        rs      = ri;
        e.flags = ef;
        e.tdo   = et;
        e.par   = ep;
        e.tag   = tag;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = sb_q.pop_front();
        flags = {bus.reset, bus.run, bus.capture, bus.shift, bus.update, bus.len_err};
        n_tests += 3;
        assert (flags === g.flags) else begin
            n_fail++;
            $error("FAIL %s flags got %b expected %b", g.tag, flags, g.flags);
        end
        assert (bus.tdo === g.tdo) else begin
            n_fail++;
            $error("FAIL %s tdo got %b expected %b", g.tag, bus.tdo, g.tdo);
        end
        assert (bus.par_out === g.par) else begin
            n_fail++;
            $error("FAIL %s par_out got %h expected %h", g.tag, bus.par_out, g.par);
        end
    endtask

    // Full 8-bit scan starting in RI: capture cap, shift din LSB-first, update.
    task automatic scan8(input logic [7:0] cap, input logic [7:0] din,
                         input logic [7:0] old_par, input string tag);
        bus.par_in = cap;
        step(1'b1, 1'b0, 1'b0, F_CAP, 1'b0, old_par, {tag, "_cap"});
        step(1'b0, 1'b0, 1'b0, F_SH, cap[0], old_par, {tag, "_sh0"});
        for (int k = 0; k < 7; k++) begin
            step(1'b0, din[k], 1'b0, F_SH, cap[k+1], old_par, {tag, "_shift"});
        end
        step(1'b1, din[7], 1'b0, F_EX, 1'b0, old_par, {tag, "_ex"});
        step(1'b1, 1'b0, 1'b0, F_UP, 1'b0, old_par, {tag, "_up"});
        step(1'b0, 1'b0, 1'b0, F_RI, 1'b0, din, {tag, "_upd"});
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rs         = 1'b1;
        bus.x      = 1'b0;
        bus.tdi    = 1'b0;
        bus.par_in = 8'hA5;
`ifdef SCAN_BYPASS_EN
        bus.byp    = 1'b0;
`endif

        // Reset and release.
        step(1'b0, 1'b0, 1'b1, F_RS, 1'b0, 8'h00, "rst1");
        step(1'b0, 1'b0, 1'b1, F_RS, 1'b0, 8'h00, "rst2");
        step(1'b0, 1'b0, 1'b0, F_RI, 1'b0, 8'h00, "rs_to_ri");

        // Good 8-bit scan: capture A5, shift in 3C.
        step(1'b0, 1'b0, 1'b0, F_RI, 1'b0, 8'h00, "ri_hold");
        scan8(8'hA5, 8'h3C, 8'h00, "main");

        // Short scan of 6 bits: no update, one-cycle len_err.
        bus.par_in = 8'h5A;
        step(1'b1, 1'b0, 1'b0, F_CAP, 1'b0, 8'h3C, "short_cap");
        step(1'b0, 1'b0, 1'b0, F_SH, 1'b0, 8'h3C, "short_sh0");
        for (int m = 1; m <= 5; m++) begin
            step(1'b0, 1'b1, 1'b0, F_SH, bus.par_in[m], 8'h3C, "short_shift");
        end
        step(1'b1, 1'b1, 1'b0, F_EX, 1'b0, 8'h3C, "short_ex");
        step(1'b1, 1'b0, 1'b0, F_UP, 1'b0, 8'h3C, "short_up");
        step(1'b0, 1'b0, 1'b0, F_RI | F_LE, 1'b0, 8'h3C, "len_err_pulse");
        step(1'b0, 1'b0, 1'b0, F_RI, 1'b0, 8'h3C, "len_err_clear");

        // Forced reset: five consecutive x=1 edges starting from SH.
        step(1'b1, 1'b0, 1'b0, F_CAP, 1'b0, 8'h3C, "frc_cap");
        step(1'b0, 1'b0, 1'b0, F_SH, 1'b0, 8'h3C, "frc_sh");
        step(1'b1, 1'b0, 1'b0, F_EX, 1'b0, 8'h3C, "frc_x1_ex");
        step(1'b1, 1'b0, 1'b0, F_UP, 1'b0, 8'h3C, "frc_x2_up");
        step(1'b1, 1'b0, 1'b0, F_CAP | F_LE, 1'b0, 8'h3C, "frc_x3_cap");
        step(1'b1, 1'b0, 1'b0, F_EX, 1'b0, 8'h3C, "frc_x4_ex");
        step(1'b1, 1'b0, 1'b0, F_RS, 1'b0, 8'h3C, "frc_x5_rs");
        step(1'b1, 1'b0, 1'b0, F_RS, 1'b0, 8'h3C, "frc_rs_hold");
        step(1'b0, 1'b0, 1'b0, F_RI, 1'b0, 8'h3C, "frc_to_ri");

        // rs asserted mid-shift, then a full scan works normally.
        bus.par_in = 8'hA5;
        step(1'b1, 1'b0, 1'b0, F_CAP, 1'b0, 8'h3C, "mid_cap");
        step(1'b0, 1'b0, 1'b0, F_SH, 1'b1, 8'h3C, "mid_sh0");
        step(1'b0, 1'b1, 1'b0, F_SH, 1'b0, 8'h3C, "mid_sh1");
        step(1'b0, 1'b0, 1'b1, F_RS, 1'b0, 8'h00, "mid_rs");
        step(1'b0, 1'b0, 1'b0, F_RI, 1'b0, 8'h00, "mid_to_ri");
        scan8(8'h96, 8'hC3, 8'h00, "post_rs");

`ifdef SCAN_BYPASS_EN
        // Bypass scan: one shift through the bypass bit, no update, no error.
        bus.par_in = 8'hFF;
        step(1'b1, 1'b0, 1'b0, F_CAP, 1'b0, 8'hC3, "byp_cap");
        bus.byp = 1'b1;
        step(1'b0, 1'b0, 1'b0, F_SH, 1'b0, 8'hC3, "byp_sh");
        bus.byp = 1'b0;
        step(1'b1, 1'b1, 1'b0, F_EX, 1'b0, 8'hC3, "byp_ex");
        step(1'b1, 1'b0, 1'b0, F_UP, 1'b0, 8'hC3, "byp_up");
        step(1'b0, 1'b0, 1'b0, F_RI, 1'b0, 8'hC3, "byp_done");
        scan8(8'h5A, 8'h69, 8'hC3, "post_byp");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_ctrl.md
Name: scan_ctrl

Overview:
- Parametrised successor to the team's 4-state scan-mode FSM.
- Adds capture and exit states, an owned DW-bit serial shift register with parallel capture/update, a shift-length check, and a forced reset after RST_CNT consecutive x=1 cycles.
- Sits between a serial test port (x/tdi/tdo) and on-chip parallel test registers.

Parameters:
- DW, 8, shift/update register width (>=2).
- RST_CNT, 5, consecutive x=1 sampled edges that force state RS from any state (>=2).

Ports:
- clk  input  1  clock; all logic on posedge
- rs  input  1  synchronous active-high reset
- x  input  1  mode/steer input sampled each posedge
- tdi  input  1  serial data in
- tdo  output  1  serial data out
- par_in  input  DW  parallel capture data
- par_out  output  DW  update register
- reset  output  1  high in state RS
- run  output  1  high in state RI
- capture  output  1  high in state CAP
- shift  output  1  high in state SH
- update  output  1  high in state UP
- len_err  output  1  one-cycle pulse, in UP with wrong shift count

Behaviour:
- State register one-hot, 6 states: RS, RI, CAP, SH, EX, UP.
- Moore outputs reset/run/capture/shift/update equal the state bits directly (registered, no combinational path from x).
- rs=1 at posedge: state<=RS, sr<=0, par_out<=0, cnt<=0, x-run counter<=0, len_err<=0. rs has priority over everything.
- Reset values: reset=1; run/capture/shift/update/len_err/tdo=0; par_out=0.
- Transitions, x sampled at posedge:
  - RS: x=0 -> RI; x=1 -> RS.
  - RI: x=1 -> CAP; x=0 -> RI.
  - CAP: x=0 -> SH; x=1 -> EX.
  - SH: x=0 -> SH; x=1 -> EX.
  - EX: x=0 -> SH; x=1 -> UP.
  - UP: x=0 -> RI; x=1 -> CAP.
- Datapath actions happen on the edge leaving the named state:
  - CAP: sr<=par_in; cnt<=0.
  - SH: sr<={tdi, sr[DW-1:1]}; cnt<=cnt+1, saturating at DW+1.
  - UP: if cnt==DW then par_out<=sr, else par_out holds.
- len_err: registered; asserted for exactly the one cycle after leaving UP with cnt!=DW.
- tdo = sr[0] while shift=1, else 0. Combinational from registers only.
- Forced reset:
  - xrun counts consecutive x=1 edges; cleared on any x=0.
  - When xrun reaches RST_CNT-1 and x=1, next state is RS regardless of the transition table.
  - xrun saturates at RST_CNT-1.
  - Datapath actions of the current state still occur on that edge; par_out is still updated if the state was UP.
- cnt width: clog2(DW+2).
- EX -> SH resumes shifting without clearing cnt.

Optional Feature:
- Macro: SCAN_BYPASS_EN.
- When defined:
  - Extra input byp (1 bit), sampled in CAP and latched into byp_q until the next CAP or rs.
  - With byp_q=1: CAP loads a 1-bit bypass reg with 0; SH shifts tdi through the bypass reg; tdo = bypass reg; sr is untouched; UP never writes par_out; length check expects cnt==1.
- When undefined: no byp port; behaviour exactly as above.

Decomposition:
- Package scan_pkg: state one-hot localparams (ST_RS..ST_UP), state typedef, clog2 helper.
- Sub-module scan_sreg(DW): capture/shift/update register plus cnt, controlled by the capture/shift/update enables.
- FSM and forced-reset counter stay in scan_ctrl.

Test Plan:
- rs=1 for 2 cycles, then x=0 -> reset=1 for the rs cycles, then run=1 one cycle after the x=0 edge; par_out=0, tdo=0.
- DW=8, par_in=8'hA5:
  - x sequence 0,1,0 then 7 more x=0 edges in SH, then x=1,1 with tdi pattern 8'h3C LSB-first.
  - tdo shows 1,0,1,0,0,1,0,1; par_out=8'h3C after UP; len_err=0.
- Shift only 6 bits, then EX->UP -> par_out unchanged, len_err pulses high exactly 1 cycle.
- SH with x=1 for 5 consecutive edges (RST_CNT=5) -> passes EX, UP, CAP, then reset=1 on the 5th edge.
- SCAN_BYPASS_EN with byp=1 at CAP, 1 shift of tdi=1 -> tdo=0 during shift; par_out unchanged; len_err=0.
- rs asserted mid-SH -> next cycle reset=1, sr=0, cnt=0; a subsequent full 8-bit scan works normally.
